// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, bit functions and FSM state type
package sha256_pkg;

    typedef logic [31:0]       word_t;
    typedef logic [0:7][31:0]  hash_t;   // index 0 = a / H0 (most significant)
    typedef logic [0:15][31:0] block_t;  // index 0 = word 0 of a block

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t state_in,
    input  word_t w,
    input  word_t k,
    output hash_t state_out
);

    word_t t1;
    word_t t2;

    // Standard round: shift the working variables and inject T1/T2 at a and e
    always_comb begin
        t1 = state_in[7] + bsig1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6]) + k + w;
        t2 = bsig0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
        state_out    = state_in;
        state_out[0] = t1 + t2;
        state_out[1] = state_in[0];
        state_out[2] = state_in[1];
        state_out[3] = state_in[2];
        state_out[4] = state_in[3] + t1;
        state_out[5] = state_in[4];
        state_out[6] = state_in[5];
        state_out[7] = state_in[6];
    end

endmodule

// File: rtl/sha256_multiblock.sv
// rtl/sha256_multiblock.sv - multi-block SHA-256 core, one round per clock; optional SHA256D_EN double hash
module sha256_multiblock
    import sha256_pkg::*;
#(
    parameter  int NBLOCKS = 2,
    localparam int MSG_W   = 512 * NBLOCKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] message,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     digest,
    output logic             busy
);

    localparam int BLK_W = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;

    state_t            state;
    state_t            state_next;
    logic [MSG_W-1:0]  msg_rest;   // blocks still to be hashed, next one at the top
    hash_t             hreg;
    hash_t             work;
    hash_t             round_out;
    hash_t             h_sum;
    block_t            win;
    word_t             w_new;
    logic [5:0]        t;
    logic [BLK_W-1:0]  blk;
    logic              last_blk;
`ifdef SHA256D_EN
    logic              second;     // running the outer hash of the double pass
`endif

    assign last_blk = (blk == BLK_W'(NBLOCKS - 1));

    // Window holds W[t..t+15]; the appended word is W[t+16]
    assign w_new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

    // Chaining value plus working variables, used at the end of every block
    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = hreg[i] + work[i];
        end
    end

    sha256_round u_round (
        .state_in  (work),
        .w         (win[0]),
        .k         (K[t]),
        .state_out (round_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (in_valid) state_next = ST_ROUND;
            ST_ROUND: if (t == 6'd63) state_next = ST_ADD;
            ST_ADD: begin
                if (!last_blk) begin
                    state_next = ST_ROUND;
                end
`ifdef SHA256D_EN
                else if (!second) begin
                    state_next = ST_ROUND;
                end
`endif
                else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE:  in_ready  = 1'b1;
            ST_ROUND: busy      = 1'b1;
            ST_ADD:   busy      = 1'b1;
            ST_DONE:  out_valid = 1'b1;
            default:  in_ready  = 1'b0;
        endcase
    end

    // Datapath: message latch, schedule window, working vars, chaining value, digest
    always_ff @(posedge clk) begin
        if (!rst) begin
            msg_rest <= '0;
            hreg     <= '0;
            work     <= '0;
            win      <= '0;
            t        <= '0;
            blk      <= '0;
            digest   <= '0;
`ifdef SHA256D_EN
            second   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        win      <= message[MSG_W-1 -: 512];
                        msg_rest <= message << 512;
                        hreg     <= IV;
                        work     <= IV;
                        t        <= '0;
                        blk      <= '0;
`ifdef SHA256D_EN
                        second   <= 1'b0;
`endif
                    end
                end
                ST_ROUND: begin
                    work <= round_out;
                    win  <= {win[1:15], w_new};
                    t    <= t + 6'd1;
                end
                ST_ADD: begin
                    hreg <= h_sum;
                    t    <= '0;
                    if (!last_blk) begin
                        blk      <= blk + BLK_W'(1);
                        work     <= h_sum;
                        win      <= msg_rest[MSG_W-1 -: 512];
                        msg_rest <= msg_rest << 512;
                    end
`ifdef SHA256D_EN
                    else if (!second) begin
                        // Outer hash: single padded block carrying the 256-bit inner digest
                        second <= 1'b1;
                        hreg   <= IV;
                        work   <= IV;
                        win    <= {h_sum, 32'h80000000, 192'h0, 32'h00000100};
                    end
`endif
                    else begin
                        digest <= h_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
